vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
Raster timing generator that sits directly upstream of the pixel painting/readout stage. It produces the pixel coordinates cur_x/cur_y that stage uses to window the image and step its memory address, plus the hsync/vsync/video_on signals for the VGA DAC. It is built from free-running horizontal and vertical counters, advanced by an internal pixel-clock divider, with 640x480@60 Hz default timing.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1; 50 MHz clk -> 25 MHz pixel)
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
enable  in  1  run/freeze control
cur_x  out  10  horizontal count, 0..H_TOTAL-1
cur_y  out  10  vertical count, 0..V_TOTAL-1
hsync  out  1  horizontal sync, level set by SYNC_POL
vsync  out  1  vertical sync, level set by SYNC_POL
video_on  out  1  high when cur_x<H_VISIBLE and cur_y<V_VISIBLE
pix_tick  out  1  high for the first clk of each pixel period
line_start  out  1  high for the first clk of each cur_x==0 period
frame_start  out  1  high for the first clk of the (0,0) period

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n). All outputs are registered.
- Totals: H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525). Both must be <=1024; elaboration fails otherwise.
- Reset values (applied immediately on rst_n low, no clock edge needed):
  - cur_x=H_TOTAL-1 and cur_y=V_TOTAL-1, so the counters sit at the last blanking pixel.
  - hsync=vsync=~SYNC_POL (inactive).
  - video_on=0, pix_tick=0, line_start=0, frame_start=0.
  - Divider count=0.
- Divider:
  - div counts 0..CLK_DIV-1 while enable=1.
  - The advance edge is the clk edge where div==CLK_DIV-1; div wraps to 0 on that edge.
  - CLK_DIV=1: every edge is an advance edge.
- Advance edge:
  - cur_x increments; at H_TOTAL-1 it wraps to 0 and cur_y increments.
  - cur_y wraps from V_TOTAL-1 to 0 when cur_x also wraps.
- Output alignment:
  - hsync, vsync and video_on are computed from the next counter values, so they change on the same edge as cur_x/cur_y (zero skew).
  - hsync is active for cur_x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vsync is active for cur_y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491.
- Strobes:
  - pix_tick=1 for exactly one clk after each advance edge.
  - line_start=1 when that advance produced cur_x=0.
  - frame_start=1 when it produced (0,0).
  - With CLK_DIV=1, pix_tick stays 1 while enable=1.
- Reset release: the first advance edge comes CLK_DIV clks after release. It yields (0,0) with frame_start, line_start, pix_tick and video_on all 1.
- enable=0:
  - div and both counters hold.
  - pix_tick, line_start and frame_start are forced to 0.
  - hsync, vsync and video_on hold.
  - enable=1 resumes from the held div value; no pixel is skipped or repeated.
- Simultaneous events: rst_n low overrides enable. The wrap of cur_x and the increment/wrap of cur_y occur on the same edge.

Decomposition:
- Package vga_timing_pkg: 640x480@60 timing constants, H_TOTAL and V_TOTAL, and the coordinate width (10).
- One natural sub-module, vga_axis_counter, instantiated twice (horizontal and vertical). Its interface:
  - Inputs: step, parameter TOTAL, sync window start/end.
  - Outputs: count, wrap, visible, sync.
- Divider and strobe logic stay in the top module.

Test Plan:
1. Hold rst_n=0 -> cur_x=799, cur_y=524, hsync=vsync=1, video_on=0, all strobes 0. Release -> after 2 clk, cur=(0,0) with frame_start, line_start, video_on and pix_tick all =1 for 1 clk.
2. Run 1 line -> line period 1600 clk; hsync low exactly while cur_x=656..751 (192 clk); line_start pulses once per line.
3. Run 2 frames -> frame period 840000 clk; vsync low only for cur_y=490..491 (3200 clk); exactly one frame_start per frame.
4. Visible-area boundaries -> video_on=1 at cur_x=639 and 0 at 640; video_on=1 at cur_y=479 and 0 at 480; wrap 799->0 increments cur_y on the same edge.
5. At cur_x=100, drop enable for 10 clk -> cur_x stays 100, pix_tick=0; after re-enable cur_x reaches 101 within 2 clk, no skipped value.
6. Assert rst_n=0 mid-frame at cur_y=300, between clk edges -> outputs take reset values immediately; after release the sequence restarts as in scenario 1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 Hz raster timing and coordinate width.
package vga_timing_pkg;

    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; wrapping counter with visible/sync decode of its next value.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = DEF_H_TOTAL,
    parameter int VISIBLE    = DEF_H_VISIBLE,
    parameter int SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT,
    parameter int SYNC_END   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC - 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               visible,
    output logic               sync
);

    logic [COORD_W-1:0] count_q, count_d;

    // visible/sync decode the upcoming count so the top can register them alongside it
    always_comb begin
        wrap    = step && (count_q == COORD_W'(TOTAL - 1));
        count_d = !step ? count_q : wrap ? '0 : count_q + COORD_W'(1);
        visible = count_d < COORD_W'(VISIBLE);
        sync    = (count_d >= COORD_W'(SYNC_START)) && (count_d <= COORD_W'(SYNC_END));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= COORD_W'(TOTAL - 1);
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator; pixel divider, h/v counters, syncs and pixel/line/frame strobes.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV   = 2,
    parameter int   H_VISIBLE = DEF_H_VISIBLE,
    parameter int   H_FRONT   = DEF_H_FRONT,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BACK    = DEF_H_BACK,
    parameter int   V_VISIBLE = DEF_V_VISIBLE,
    parameter int   V_FRONT   = DEF_V_FRONT,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BACK    = DEF_V_BACK,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               pix_tick,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX || CLK_DIV < 1) begin : g_bad_cfg
        $error("vga_sync_gen: unsupported timing configuration");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             adv;
    logic             h_wrap, h_vis, h_sync;
    logic             v_wrap, v_vis, v_sync;
    logic             hsync_q, vsync_q, video_q, pix_q, line_q, frame_q;

    always_comb begin
        adv   = enable && (div_q == DIV_W'(CLK_DIV - 1));
        div_d = !enable ? div_q : adv ? '0 : div_q + DIV_W'(1);
    end

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (H_VISIBLE + H_FRONT),
        .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC - 1)
    ) u_h (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (adv),
        .count   (cur_x),
        .wrap    (h_wrap),
        .visible (h_vis),
        .sync    (h_sync)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (V_VISIBLE + V_FRONT),
        .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC - 1)
    ) u_v (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (h_wrap),
        .count   (cur_y),
        .wrap    (v_wrap),
        .visible (v_vis),
        .sync    (v_sync)
    );

    // h_wrap/v_wrap already include the advance qualifier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            video_q <= 1'b0;
            pix_q   <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            pix_q   <= adv;
            line_q  <= h_wrap;
            frame_q <= v_wrap;
            if (adv) begin
                hsync_q <= h_sync ? SYNC_POL : ~SYNC_POL;
                vsync_q <= v_sync ? SYNC_POL : ~SYNC_POL;
                video_q <= h_vis && v_vis;
            end
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_q;
    assign pix_tick    = pix_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: default-timing instance (a) for line-level checks, tiny CLK_DIV=1 instance (b) for frame-level checks.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_a, en_a, rst_n_b, en_b;
    logic [9:0] cur_x_a, cur_y_a, cur_x_b, cur_y_b;
    logic       hsync_a, vsync_a, video_on_a, pix_tick_a, line_start_a, frame_start_a;
    logic       hsync_b, vsync_b, video_on_b, pix_tick_b, line_start_b, frame_start_b;

    vga_sync_gen u_a (
        .clk(clk), .rst_n(rst_n_a), .enable(en_a),
        .cur_x(cur_x_a), .cur_y(cur_y_a), .hsync(hsync_a), .vsync(vsync_a),
        .video_on(video_on_a), .pix_tick(pix_tick_a),
        .line_start(line_start_a), .frame_start(frame_start_a)
    );

    // 15 x 10 raster: hsync x=10..12, vsync y=7..8, visible 8x6, active-high syncs
    vga_sync_gen #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1)
    ) u_b (
        .clk(clk), .rst_n(rst_n_b), .enable(en_b),
        .cur_x(cur_x_b), .cur_y(cur_y_b), .hsync(hsync_b), .vsync(vsync_b),
        .video_on(video_on_b), .pix_tick(pix_tick_b),
        .line_start(line_start_b), .frame_start(frame_start_b)
    );

    typedef struct {
        int         clks;
        int         x;
        int         y;
        logic [5:0] flags;
    } vec_t;

    vec_t va[16];
    vec_t vb[16];
    int   checks = 0;
    int   errors = 0;
    int   hlow_a, ls_a, fs_b, vact_b, von_b, pix_b, kb, fs_t0, fs_t1, bad;

    function automatic logic [25:0] pk_a();
        return {cur_x_a, cur_y_a, hsync_a, vsync_a, video_on_a, pix_tick_a, line_start_a, frame_start_a};
    endfunction

    function automatic logic [25:0] pk_b();
        return {cur_x_b, cur_y_b, hsync_b, vsync_b, video_on_b, pix_tick_b, line_start_b, frame_start_b};
    endfunction

    function automatic logic [25:0] mk(input int x, input int y, input logic [5:0] f);
        logic [9:0] xx, yy;
        xx = x[9:0];
        yy = y[9:0];
        return {xx, yy, f};
    endfunction

    task automatic check(input string name, input logic [25:0] got, input logic [25:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d hs/vs/von/pix/ls/fs=%b, expected x=%0d y=%0d hs/vs/von/pix/ls/fs=%b",
                     name, got[25:16], got[15:6], got[5:0], exp[25:16], exp[15:6], exp[5:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        kb++;
        hlow_a += int'(!hsync_a);
        ls_a   += int'(line_start_a);
        vact_b += int'(vsync_b);
        von_b  += int'(video_on_b);
        pix_b  += int'(pix_tick_b);
        if (frame_start_b) begin
            if (fs_b == 0) fs_t0 = kb;
            else           fs_t1 = kb;
            fs_b++;
        end
    endtask

    task automatic clear_acc();
        hlow_a = 0; ls_a = 0; fs_b = 0; vact_b = 0; von_b = 0; pix_b = 0;
        kb = 0; fs_t0 = 0; fs_t1 = 0;
    endtask

    initial begin
        // {clks since previous vector, x, y, hs vs von pix ls fs}
        va[0]  = '{0,    799, 524, 6'b110000};
        va[1]  = '{1,    799, 524, 6'b110000};
        va[2]  = '{1,    0,   0,   6'b111111};
        va[3]  = '{1,    0,   0,   6'b111000};
        va[4]  = '{1,    1,   0,   6'b111100};
        va[5]  = '{1276, 639, 0,   6'b111100};
        va[6]  = '{1,    639, 0,   6'b111000};
        va[7]  = '{1,    640, 0,   6'b110100};
        va[8]  = '{30,   655, 0,   6'b110100};
        va[9]  = '{2,    656, 0,   6'b010100};
        va[10] = '{190,  751, 0,   6'b010100};
        va[11] = '{2,    752, 0,   6'b110100};
        va[12] = '{94,   799, 0,   6'b110100};
        va[13] = '{1,    799, 0,   6'b110000};
        va[14] = '{1,    0,   1,   6'b111110};
        va[15] = '{1,    0,   1,   6'b111000};

        vb[0]  = '{1,  0,  0, 6'b001111};
        vb[1]  = '{1,  1,  0, 6'b001100};
        vb[2]  = '{6,  7,  0, 6'b001100};
        vb[3]  = '{1,  8,  0, 6'b000100};
        vb[4]  = '{2,  10, 0, 6'b100100};
        vb[5]  = '{2,  12, 0, 6'b100100};
        vb[6]  = '{1,  13, 0, 6'b000100};
        vb[7]  = '{1,  14, 0, 6'b000100};
        vb[8]  = '{1,  0,  1, 6'b001110};
        vb[9]  = '{67, 7,  5, 6'b001100};
        vb[10] = '{1,  8,  5, 6'b000100};
        vb[11] = '{7,  0,  6, 6'b000110};
        vb[12] = '{15, 0,  7, 6'b010110};
        vb[13] = '{30, 0,  9, 6'b000110};
        vb[14] = '{14, 14, 9, 6'b000100};
        vb[15] = '{1,  0,  0, 6'b001111};

        rst_n_a = 1'b0; rst_n_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
        clear_acc();
        repeat (3) @(negedge clk);
        check("a reset", pk_a(), mk(799, 524, 6'b110000));
        check("b reset", pk_b(), mk(14, 9, 6'b000000));

        rst_n_a = 1'b1;
        clear_acc();
        for (int i = 0; i < 16; i++) begin
            repeat (va[i].clks) tick();
            check($sformatf("a vec %0d", i), pk_a(), mk(va[i].x, va[i].y, va[i].flags));
        end
        check_int("a hsync low clks per line", hlow_a, 192);
        check_int("a line_start pulses", ls_a, 2);

        repeat (199) tick();
        check("a x100", pk_a(), mk(100, 1, 6'b111100));
        en_a = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cur_x_a != 10'd100 || pix_tick_a || line_start_a || !video_on_a || !hsync_a) bad++;
        end
        check_int("a freeze hold cycles wrong", bad, 0);
        en_a = 1'b1;
        tick();
        check("a resume 1", pk_a(), mk(100, 1, 6'b111000));
        tick();
        check("a resume 2", pk_a(), mk(101, 1, 6'b111100));

        #2 rst_n_a = 1'b0;
        #1 check("a async reset", pk_a(), mk(799, 524, 6'b110000));
        repeat (2) @(negedge clk);
        rst_n_a = 1'b1;
        tick();
        check("a rerelease 1", pk_a(), mk(799, 524, 6'b110000));
        tick();
        check("a rerelease 2", pk_a(), mk(0, 0, 6'b111111));

        rst_n_b = 1'b1;
        clear_acc();
        for (int i = 0; i < 16; i++) begin
            repeat (vb[i].clks) tick();
            check($sformatf("b vec %0d", i), pk_b(), mk(vb[i].x, vb[i].y, vb[i].flags));
        end
        repeat (149) tick();
        check_int("b frame_start count", fs_b, 2);
        check_int("b frame period", fs_t1 - fs_t0, 150);
        check_int("b vsync active clks", vact_b, 60);
        check_int("b video_on clks", von_b, 96);
        check_int("b pix_tick clks", pix_b, 300);

        repeat (46) tick();
        check("b mid frame", pk_b(), mk(0, 3, 6'b001110));
        #2 rst_n_b = 1'b0;
        #1 check("b async reset", pk_b(), mk(14, 9, 6'b000000));
        repeat (2) @(negedge clk);
        rst_n_b = 1'b1;
        tick();
        check("b rerelease", pk_b(), mk(0, 0, 6'b001111));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
